// File: rtl/bc_polinomio_pkg.sv
// Shared encodings for the polynomial controller (bc_polinomio) and its datapath (BO).
// Both sides import this package so mux selects and ULA ops always agree.
package bc_polinomio_pkg;

    localparam int DATA_W = 16;

    typedef enum logic [2:0] {
        ST_INICIO    = 3'd0,
        ST_CARREGA_X = 3'd1,
        ST_MUL_A     = 3'd2,
        ST_SOMA_B    = 3'd3,
        ST_MUL_X     = 3'd4,
        ST_SOMA_C    = 3'd5,
        ST_FIM       = 3'd6
    } state_t;

    // m0: coefficient mux
    localparam logic [1:0] SEL_ZERO = 2'b00;
    localparam logic [1:0] SEL_A    = 2'b01;
    localparam logic [1:0] SEL_B    = 2'b10;
    localparam logic [1:0] SEL_C    = 2'b11;

    // m1: ULA operand B
    localparam logic [1:0] SEL_COEF = 2'b00;
    localparam logic [1:0] SEL_X    = 2'b01;
    localparam logic [1:0] SEL_S    = 2'b10;
    localparam logic [1:0] SEL_H    = 2'b11;

    // m2: ULA operand A -- coefficient and X swap codes relative to m1
    localparam logic [1:0] SELA_X    = 2'b00;
    localparam logic [1:0] SELA_COEF = 2'b01;
    localparam logic [1:0] SELA_S    = 2'b10;
    localparam logic [1:0] SELA_H    = 2'b11;

    localparam logic OP_SOMA = 1'b0;
    localparam logic OP_MULT = 1'b1;

    typedef struct packed {
        logic [1:0] m0;
        logic [1:0] m1;
        logic [1:0] m2;
        logic       lx;
        logic       lh;
        logic       ls;
        logic       h;
        logic       ocupado;
        logic       pronto;
    } ctrl_t;

    function automatic ctrl_t ctrl_default();
        ctrl_t v;
        v.m0      = SEL_ZERO;
        v.m1      = SEL_COEF;
        v.m2      = SELA_X;
        v.lx      = 1'b0;
        v.lh      = 1'b0;
        v.ls      = 1'b0;
        v.h       = OP_SOMA;
        v.ocupado = 1'b0;
        v.pronto  = 1'b0;
        return v;
    endfunction

    // Products keep only the low DATA_W bits; sums wrap naturally.
    function automatic logic [DATA_W-1:0] ula(input logic op,
                                              input logic [DATA_W-1:0] op_a,
                                              input logic [DATA_W-1:0] op_b);
        logic [2*DATA_W-1:0] prod;
        logic [DATA_W-1:0]   sum;
        prod = {{DATA_W{1'b0}}, op_a} * {{DATA_W{1'b0}}, op_b};
        sum  = op_a + op_b;
        return (op == OP_MULT) ? prod[DATA_W-1:0] : sum;
    endfunction

endpackage

// File: rtl/BO.sv
// Polynomial datapath: X/H/S registers, coefficient mux and a single add/multiply ULA.
// Registers have no reset; stale contents are harmless because pronto gates their use.
module BO
    import bc_polinomio_pkg::*;
(
    input  logic              i_clk,
    input  logic [DATA_W-1:0] i_a,
    input  logic [DATA_W-1:0] i_b,
    input  logic [DATA_W-1:0] i_c,
    input  logic [DATA_W-1:0] i_x,
    input  logic [1:0]        i_m0,
    input  logic [1:0]        i_m1,
    input  logic [1:0]        i_m2,
    input  logic              i_lx,
    input  logic              i_lh,
    input  logic              i_ls,
    input  logic              i_h,
    output logic [DATA_W-1:0] o_resultado
);

    logic [DATA_W-1:0] r_x;
    logic [DATA_W-1:0] r_h;
    logic [DATA_W-1:0] r_s;
    logic [DATA_W-1:0] w_coef;
    logic [DATA_W-1:0] w_op_a;
    logic [DATA_W-1:0] w_op_b;
    logic [DATA_W-1:0] w_ula;

    always_comb begin
        w_coef = '0;
        unique case (i_m0)
            SEL_ZERO: w_coef = '0;
            SEL_A:    w_coef = i_a;
            SEL_B:    w_coef = i_b;
            SEL_C:    w_coef = i_c;
            default:  w_coef = '0;
        endcase
    end

    always_comb begin
        w_op_b = '0;
        unique case (i_m1)
            SEL_COEF: w_op_b = w_coef;
            SEL_X:    w_op_b = r_x;
            SEL_S:    w_op_b = r_s;
            SEL_H:    w_op_b = r_h;
            default:  w_op_b = '0;
        endcase
    end

    always_comb begin
        w_op_a = '0;
        unique case (i_m2)
            SELA_X:    w_op_a = r_x;
            SELA_COEF: w_op_a = w_coef;
            SELA_S:    w_op_a = r_s;
            SELA_H:    w_op_a = r_h;
            default:   w_op_a = '0;
        endcase
    end

    assign w_ula = ula(i_h, w_op_a, w_op_b);

    always_ff @(posedge i_clk) begin
        if (i_lx) r_x <= i_x;
        if (i_lh) r_h <= w_ula;
        if (i_ls) r_s <= w_ula;
    end

    assign o_resultado = r_s;

endmodule

// File: rtl/polinomio_top.sv
// System wrapper: controller bc_polinomio driving datapath BO on a shared clock.
module polinomio_top
    import bc_polinomio_pkg::*;
(
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_start,
    input  logic [DATA_W-1:0] i_a,
    input  logic [DATA_W-1:0] i_b,
    input  logic [DATA_W-1:0] i_c,
    input  logic [DATA_W-1:0] i_x,
    output logic [DATA_W-1:0] o_resultado,
    output logic              o_pronto,
    output logic              o_ocupado
);

    logic [1:0] w_m0;
    logic [1:0] w_m1;
    logic [1:0] w_m2;
    logic       w_lx;
    logic       w_lh;
    logic       w_ls;
    logic       w_h;

    bc_polinomio u_bc (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_start   (i_start),
        .o_m0      (w_m0),
        .o_m1      (w_m1),
        .o_m2      (w_m2),
        .o_lx      (w_lx),
        .o_lh      (w_lh),
        .o_ls      (w_ls),
        .o_h       (w_h),
        .o_ocupado (o_ocupado),
        .o_pronto  (o_pronto)
    );

    BO u_bo (
        .i_clk       (i_clk),
        .i_a         (i_a),
        .i_b         (i_b),
        .i_c         (i_c),
        .i_x         (i_x),
        .i_m0        (w_m0),
        .i_m1        (w_m1),
        .i_m2        (w_m2),
        .i_lx        (w_lx),
        .i_lh        (w_lh),
        .i_ls        (w_ls),
        .i_h         (w_h),
        .o_resultado (o_resultado)
    );

endmodule

// File: rtl/bc_polinomio.sv
// Moore controller sequencing BO through a*x^2 + b*x + c by Horner's rule.
// state        | meaning
// INICIO       | idle, waiting for start
// CARREGA_X    | latch x into X
// MUL_A        | H <- a*X
// SOMA_B       | H <- H + b
// MUL_X        | H <- H*X
// SOMA_C       | S <- H + c
// FIM          | pronto pulse, resultado valid
module bc_polinomio
    import bc_polinomio_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_start,
    output logic [1:0] o_m0,
    output logic [1:0] o_m1,
    output logic [1:0] o_m2,
    output logic       o_lx,
    output logic       o_lh,
    output logic       o_ls,
    output logic       o_h,
    output logic       o_ocupado,
    output logic       o_pronto
);

    state_t r_state;
    state_t w_next;
    ctrl_t  w_ctrl;

    always_ff @(posedge i_clk) begin
        if (i_rst) r_state <= ST_INICIO;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = ST_INICIO;
        unique case (r_state)
            ST_INICIO:    w_next = i_start ? ST_CARREGA_X : ST_INICIO;
            ST_CARREGA_X: w_next = ST_MUL_A;
            ST_MUL_A:     w_next = ST_SOMA_B;
            ST_SOMA_B:    w_next = ST_MUL_X;
            ST_MUL_X:     w_next = ST_SOMA_C;
            ST_SOMA_C:    w_next = ST_FIM;
            ST_FIM:       w_next = ST_INICIO;
            default:      w_next = ST_INICIO;
        endcase
    end

    always_comb begin
        w_ctrl = ctrl_default();
        unique case (r_state)
            ST_INICIO: ;
            ST_CARREGA_X: begin
                w_ctrl.lx = 1'b1;
            end
            ST_MUL_A: begin
                w_ctrl.m0 = SEL_A;
                w_ctrl.m1 = SEL_COEF;
                w_ctrl.m2 = SELA_X;
                w_ctrl.h  = OP_MULT;
                w_ctrl.lh = 1'b1;
            end
            ST_SOMA_B: begin
                w_ctrl.m0 = SEL_B;
                w_ctrl.m1 = SEL_COEF;
                w_ctrl.m2 = SELA_H;
                w_ctrl.h  = OP_SOMA;
                w_ctrl.lh = 1'b1;
            end
            ST_MUL_X: begin
                w_ctrl.m1 = SEL_X;
                w_ctrl.m2 = SELA_H;
                w_ctrl.h  = OP_MULT;
                w_ctrl.lh = 1'b1;
            end
            ST_SOMA_C: begin
                w_ctrl.m0 = SEL_C;
                w_ctrl.m1 = SEL_COEF;
                w_ctrl.m2 = SELA_H;
                w_ctrl.h  = OP_SOMA;
                w_ctrl.ls = 1'b1;
            end
            ST_FIM: begin
                w_ctrl.pronto = 1'b1;
            end
            default: ;
        endcase
        w_ctrl.ocupado = (r_state != ST_INICIO);
    end

    assign o_m0      = w_ctrl.m0;
    assign o_m1      = w_ctrl.m1;
    assign o_m2      = w_ctrl.m2;
    assign o_lx      = w_ctrl.lx;
    assign o_lh      = w_ctrl.lh;
    assign o_ls      = w_ctrl.ls;
    assign o_h       = w_ctrl.h;
    assign o_ocupado = w_ctrl.ocupado;
    assign o_pronto  = w_ctrl.pronto;

endmodule

// File: tb/tb_bc_polinomio.sv
// Bench for bc_polinomio: controller outputs checked per cycle, results checked through polinomio_top.
module tb_bc_polinomio;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] a, b, c, x;

    logic [1:0]  m0, m1, m2;
    logic        lx, lh, ls, h, ocupado, pronto;
    logic [15:0] sys_res;
    logic        sys_pronto, sys_ocupado;
    logic [11:0] obs;

    int n_total = 0;
    int n_bad   = 0;
    logic [15:0] last_res;
    logic [11:0] exp_tab [0:6];

    always #5 clk = ~clk;

    bc_polinomio u_dut (
        .i_clk(clk), .i_rst(rst), .i_start(start),
        .o_m0(m0), .o_m1(m1), .o_m2(m2),
        .o_lx(lx), .o_lh(lh), .o_ls(ls), .o_h(h),
        .o_ocupado(ocupado), .o_pronto(pronto)
    );

    polinomio_top u_sys (
        .i_clk(clk), .i_rst(rst), .i_start(start),
        .i_a(a), .i_b(b), .i_c(c), .i_x(x),
        .o_resultado(sys_res), .o_pronto(sys_pronto), .o_ocupado(sys_ocupado)
    );

    assign obs = {m0, m1, m2, lx, lh, ls, h, ocupado, pronto};

    function automatic logic [15:0] poly(input logic [15:0] pa, input logic [15:0] pb,
                                         input logic [15:0] pc, input logic [15:0] px);
        longint unsigned la, lb, lc, lxx, v;
        la = pa; lb = pb; lc = pc; lxx = px;
        v = la * lxx * lxx + lb * lxx + lc;
        return v[15:0];
    endfunction

    task automatic set_ops(input logic [15:0] pa, input logic [15:0] pb,
                           input logic [15:0] pc, input logic [15:0] px);
        a = pa; b = pb; c = pc; x = px;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0;
        set_ops(16'd0, 16'd0, 16'd0, 16'd0);
        repeat (3) @(negedge clk);
        n_total++;
        if (obs !== 12'd0) begin
            n_bad++; $display("FAIL reset_outputs: got %b want %b", obs, 12'd0);
        end
        n_total++;
        if ({sys_ocupado, sys_pronto} !== 2'b00) begin
            n_bad++; $display("FAIL reset_sys_flags: got %b want 00", {sys_ocupado, sys_pronto});
        end
        rst = 1'b0;
        repeat (2) @(negedge clk);
        n_total++;
        if (obs !== 12'd0) begin
            n_bad++; $display("FAIL idle_after_reset: got %b want %b", obs, 12'd0);
        end
    endtask

    task automatic test_single_run(input string tag, input logic [15:0] pa, input logic [15:0] pb,
                                   input logic [15:0] pc, input logic [15:0] px);
        int lat;
        logic [15:0] expv;
        expv = poly(pa, pb, pc, px);
        set_ops(pa, pb, pc, px);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat = 1;
        while (sys_pronto !== 1'b1 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        n_total++;
        if (lat !== 6) begin
            n_bad++; $display("FAIL %s_latency: got %0d want 6", tag, lat);
        end
        n_total++;
        if (sys_res !== expv) begin
            n_bad++; $display("FAIL %s_result: got %h want %h", tag, sys_res, expv);
        end
        last_res = expv;
        @(negedge clk);
    endtask

    task automatic test_state_outputs();
        logic [15:0] expv;
        int busy;
        set_ops(16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom));
        expv = poly(a, b, c, x);
        busy = 0;
        start = 1'b1;
        #1;
        n_total++;
        if (obs !== exp_tab[0]) begin
            n_bad++; $display("FAIL state_k0: got %b want %b", obs, exp_tab[0]);
        end
        @(negedge clk);
        start = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            n_total++;
            if (obs !== exp_tab[k]) begin
                n_bad++; $display("FAIL state_k%0d: got %b want %b", k, obs, exp_tab[k]);
            end
            n_total++;
            if ($countones({lx, lh, ls}) > 1) begin
                n_bad++; $display("FAIL strobes_k%0d: got %b want at most one high", k, {lx, lh, ls});
            end
            if (ocupado === 1'b1) busy++;
            @(negedge clk);
        end
        n_total++;
        if (obs !== exp_tab[0]) begin
            n_bad++; $display("FAIL state_k7: got %b want %b", obs, exp_tab[0]);
        end
        n_total++;
        if (busy !== 6) begin
            n_bad++; $display("FAIL ocupado_cycles: got %0d want 6", busy);
        end
        n_total++;
        if (sys_res !== expv) begin
            n_bad++; $display("FAIL state_run_result: got %h want %h", sys_res, expv);
        end
        last_res = expv;
    endtask

    task automatic test_busy_start();
        logic [15:0] expv;
        int n_pr, pr_at, busy;
        set_ops(16'd7, 16'd11, 16'd13, 16'd3);
        expv = poly(16'd7, 16'd11, 16'd13, 16'd3);
        n_pr = 0; pr_at = -1; busy = 0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            if (sys_pronto === 1'b1) begin n_pr++; pr_at = k; end
            if (sys_ocupado === 1'b1) busy++;
            start = (k == 2 || k == 4);
            if (k == 3) x = 16'd99;
            @(negedge clk);
        end
        start = 1'b0;
        n_total++;
        if (n_pr !== 1 || pr_at !== 6) begin
            n_bad++; $display("FAIL busy_pronto: got count=%0d at=%0d want count=1 at=6", n_pr, pr_at);
        end
        n_total++;
        if (busy !== 6) begin
            n_bad++; $display("FAIL busy_ocupado: got %0d want 6", busy);
        end
        n_total++;
        if (sys_res !== expv) begin
            n_bad++; $display("FAIL busy_result: got %h want %h", sys_res, expv);
        end
        last_res = expv;
    endtask

    task automatic test_back_to_back();
        int pr_seen;
        set_ops(16'd1, 16'd1, 16'd1, 16'd1);
        pr_seen = 0;
        start = 1'b1;
        @(negedge clk);
        for (int k = 1; k <= 14; k++) begin
            if (sys_pronto === 1'b1) begin
                pr_seen++;
                n_total++;
                if (k !== 6 && k !== 13) begin
                    n_bad++; $display("FAIL b2b_pronto_time: got k=%0d want 6 or 13", k);
                end
                n_total++;
                if (sys_res !== ((k == 6) ? 16'd3 : 16'd7)) begin
                    n_bad++; $display("FAIL b2b_result_k%0d: got %h want %h", k, sys_res,
                                      (k == 6) ? 16'd3 : 16'd7);
                end
            end
            if (k == 6) x = 16'd2;
            if (k == 8) start = 1'b0;
            @(negedge clk);
        end
        n_total++;
        if (pr_seen !== 2) begin
            n_bad++; $display("FAIL b2b_pronto_count: got %0d want 2", pr_seen);
        end
        last_res = 16'd7;
    endtask

    task automatic test_reset_mid();
        int stray;
        set_ops(16'd500, 16'd600, 16'd700, 16'd800);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        n_total++;
        if (obs !== exp_tab[4]) begin
            n_bad++; $display("FAIL mid_in_mul_x: got %b want %b", obs, exp_tab[4]);
        end
        rst = 1'b1;
        @(negedge clk);
        n_total++;
        if (obs !== 12'd0 || {sys_ocupado, sys_pronto} !== 2'b00) begin
            n_bad++; $display("FAIL mid_reset_outputs: got %b/%b want all zero", obs, {sys_ocupado, sys_pronto});
        end
        n_total++;
        if (sys_res !== last_res) begin
            n_bad++; $display("FAIL mid_reset_keeps_result: got %h want %h", sys_res, last_res);
        end
        rst = 1'b0;
        stray = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (sys_pronto !== 1'b0 || sys_ocupado !== 1'b0 || sys_res !== last_res) stray++;
        end
        n_total++;
        if (stray !== 0) begin
            n_bad++; $display("FAIL mid_reset_quiet: got %0d bad cycles want 0", stray);
        end
        test_single_run("after_reset", 16'd9, 16'd8, 16'd7, 16'd6);
    endtask

    task automatic test_rst_with_start();
        rst = 1'b1; start = 1'b1;
        @(negedge clk);
        @(negedge clk);
        n_total++;
        if (ocupado !== 1'b0 || sys_ocupado !== 1'b0) begin
            n_bad++; $display("FAIL rst_wins: got ocupado %b/%b want 0/0", ocupado, sys_ocupado);
        end
        rst = 1'b0; start = 1'b0;
        @(negedge clk);
        n_total++;
        if (obs !== 12'd0) begin
            n_bad++; $display("FAIL rst_wins_idle: got %b want %b", obs, 12'd0);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 10; i++) begin
            int lat;
            logic [15:0] expv;
            set_ops(16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom));
            expv = poly(a, b, c, x);
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            lat = 1;
            while (sys_pronto !== 1'b1 && lat < 20) begin
                @(negedge clk);
                lat++;
            end
            n_total++;
            if (lat !== 6 || sys_res !== expv) begin
                n_bad++; $display("FAIL random_%0d: got lat=%0d res=%h want lat=6 res=%h", i, lat, sys_res, expv);
            end
            last_res = expv;
            repeat (1 + $urandom_range(0, 2)) @(negedge clk);
        end
    endtask

    initial begin
        // {m0, m1, m2, lx, lh, ls, h, ocupado, pronto} expected k cycles after start is sampled
        exp_tab[0] = 12'b00_00_00_0_0_0_0_0_0;
        exp_tab[1] = 12'b00_00_00_1_0_0_0_1_0;
        exp_tab[2] = 12'b01_00_00_0_1_0_1_1_0;
        exp_tab[3] = 12'b10_00_11_0_1_0_0_1_0;
        exp_tab[4] = 12'b00_01_11_0_1_0_1_1_0;
        exp_tab[5] = 12'b11_00_11_0_0_1_0_1_0;
        exp_tab[6] = 12'b00_00_00_0_0_0_0_1_1;
        last_res = 16'd0;

        test_reset();
        test_single_run("basic", 16'd2, 16'd3, 16'd4, 16'd5);
        test_single_run("wrap", 16'h0100, 16'h0000, 16'h0007, 16'h0100);
        test_state_outputs();
        test_busy_start();
        test_back_to_back();
        test_reset_mid();
        test_rst_with_start();
        test_random();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
